// File: rtl/dual_issue_pkg.sv
// rtl/dual_issue_pkg.sv - MIPS decode constants and operand decode helper for the dual-issue queue
//
// Contents:
//   PC_W_DEF / INSTR_W_DEF  default widths of the pipe PC and instruction word
//   OP_* / FUNCT_JR         opcode and funct values recognised by the pairing logic
//   REG_RA                  link register written by jal
//   dec_t / decode()        destination, source and control-transfer decode of one instruction
//                           (a field reads 0 when the instruction does not use it)
package dual_issue_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_JR = 6'h08;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [4:0] dest;
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic       is_ctrl;
    } dec_t;

    // Register $0 doubles as "no operand": a $0 destination never creates a
    // hazard, so an unused field can safely read 0.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                d.src_a = instr[25:21];
                if (instr[5:0] == FUNCT_JR) begin
                    d.is_ctrl = 1'b1;
                end else begin
                    d.dest  = instr[15:11];
                    d.src_b = instr[20:16];
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                d.dest  = instr[20:16];
                d.src_a = instr[25:21];
            end
            OP_SW: begin
                d.src_a = instr[25:21];
                d.src_b = instr[20:16];
            end
            OP_BEQ, OP_BNE: begin
                d.src_a   = instr[25:21];
                d.src_b   = instr[20:16];
                d.is_ctrl = 1'b1;
            end
            OP_J:    d.is_ctrl = 1'b1;
            OP_JAL: begin
                d.dest    = REG_RA;
                d.is_ctrl = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dual_issue_queue_pair_check.sv
// rtl/dual_issue_queue_pair_check.sv - combinational intra-pair hazard check (module pair_check)
//
// Ports:
//   instr1, instr2   in   head and head+1 instructions (program order)
//   pair_ok          out  1 when both may issue together
//   dest1, dest2     out  decoded destinations (0 = none)
//   src2_a, src2_b   out  decoded sources of the second instruction (0 = none)
//   ctrl1            out  first instruction is a control transfer
module pair_check
    import dual_issue_pkg::*;
(
    input  logic [31:0] instr1,
    input  logic [31:0] instr2,
    output logic        pair_ok,
    output logic [4:0]  dest1,
    output logic [4:0]  dest2,
    output logic [4:0]  src2_a,
    output logic [4:0]  src2_b,
    output logic        ctrl1
);

    dec_t dec1;
    dec_t dec2;
    logic raw;
    logic waw;

    assign dec1   = decode(instr1);
    assign dec2   = decode(instr2);
    assign dest1  = dec1.dest;
    assign dest2  = dec2.dest;
    assign src2_a = dec2.src_a;
    assign src2_b = dec2.src_b;
    assign ctrl1  = dec1.is_ctrl;

    assign raw     = (dest1 != 5'd0) && ((dest1 == src2_a) || (dest1 == src2_b));
    assign waw     = (dest1 != 5'd0) && (dest1 == dest2);
    // The delay slot of a control transfer must not share its issue cycle.
    assign pair_ok = !raw && !waw && !ctrl1;

endmodule

// File: rtl/dual_issue_queue.sv
// rtl/dual_issue_queue.sv - fetch buffer and pair-issue stage for the dual-issue pipes
//
// Optional feature: DUAL_ISSUE_STATS_EN builds the stat_dual/stat_single counters;
// otherwise both outputs read 0.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   fetch_valid, fetch_valid1        fetch pair present / second word valid
//   fetch_pc, fetch_instr0/1         fetch PC (instr1 at pc+1) and words
//   fetch_ready                      at least two free entries
//   flush, issue_hold                redirect flush, downstream stall
//   issue_valid1/instr1/pc1          slot-1 registered output
//   issue_valid2/instr2/pc2          slot-2 registered output
//   stat_dual, stat_single           issue statistics
module dual_issue_queue
    import dual_issue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid,
    input  logic               fetch_valid1,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [INSTR_W-1:0] fetch_instr0,
    input  logic [INSTR_W-1:0] fetch_instr1,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               issue_hold,
    output logic               issue_valid1,
    output logic [INSTR_W-1:0] issue_instr1,
    output logic [PC_W-1:0]    issue_pc1,
    output logic               issue_valid2,
    output logic [INSTR_W-1:0] issue_instr2,
    output logic [PC_W-1:0]    issue_pc2,
    output logic [31:0]        stat_dual,
    output logic [31:0]        stat_single
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_n;
    logic             enq;
    logic             issue_en;
    logic             issue_one;
    logic             issue_two;
    logic             pair_ok;

    logic [4:0] unused_dest1;
    logic [4:0] unused_dest2;
    logic [4:0] unused_src2_a;
    logic [4:0] unused_src2_b;
    logic       unused_ctrl1;

    // Registered count only, so fetch_ready has no path from issue/hold.
    assign fetch_ready = (count <= READY_MAX);
    assign enq         = fetch_valid && fetch_ready && !flush;
    assign issue_en    = !issue_hold && !flush;
    assign rd_ptr_nx   = rd_ptr + PTR_W'(1);

    pair_check u_pair_check (
        .instr1  (mem_instr[rd_ptr][31:0]),
        .instr2  (mem_instr[rd_ptr_nx][31:0]),
        .pair_ok (pair_ok),
        .dest1   (unused_dest1),
        .dest2   (unused_dest2),
        .src2_a  (unused_src2_a),
        .src2_b  (unused_src2_b),
        .ctrl1   (unused_ctrl1)
    );

    assign issue_one = issue_en && (count != '0);
    assign issue_two = issue_one && (count >= CNT_W'(2)) && pair_ok;

    always_comb begin
        enq_n = '0;
        deq_n = '0;
        if (enq) begin
            enq_n = fetch_valid1 ? CNT_W'(2) : CNT_W'(1);
        end
        if (issue_two) begin
            deq_n = CNT_W'(2);
        end else if (issue_one) begin
            deq_n = CNT_W'(1);
        end
    end

    // Storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[wr_ptr] <= fetch_instr0;
            mem_pc[wr_ptr]    <= fetch_pc;
            if (fetch_valid1) begin
                mem_instr[wr_ptr + PTR_W'(1)] <= fetch_instr1;
                mem_pc[wr_ptr + PTR_W'(1)]    <= fetch_pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            issue_valid1 <= 1'b0;
            issue_instr1 <= '0;
            issue_pc1    <= '0;
            issue_valid2 <= 1'b0;
            issue_instr2 <= '0;
            issue_pc2    <= '0;
        end else if (flush) begin
            // Whatever was fetched this cycle is dropped: wr_ptr stays put.
            rd_ptr       <= wr_ptr;
            count        <= '0;
            issue_valid1 <= 1'b0;
            issue_valid2 <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + enq_n[PTR_W-1:0];
            rd_ptr <= rd_ptr + deq_n[PTR_W-1:0];
            count  <= count + enq_n - deq_n;
            if (issue_en) begin
                issue_valid1 <= issue_one;
                issue_valid2 <= issue_two;
                if (issue_one) begin
                    issue_instr1 <= mem_instr[rd_ptr];
                    issue_pc1    <= mem_pc[rd_ptr];
                end
                if (issue_two) begin
                    issue_instr2 <= mem_instr[rd_ptr_nx];
                    issue_pc2    <= mem_pc[rd_ptr_nx];
                end
            end
        end
    end

`ifdef DUAL_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dual   <= '0;
            stat_single <= '0;
        end else if (issue_two) begin
            stat_dual <= stat_dual + 32'd1;
        end else if (issue_one) begin
            stat_single <= stat_single + 32'd1;
        end
    end
`else
    assign stat_dual   = '0;
    assign stat_single = '0;
`endif

endmodule
